// File: rtl/ysyx_23060236_icache.sv
// Direct-mapped instruction cache with combinational read and an externally driven 8-beat line fill.
// Only the valid bits are reset; tag and data arrays hold whatever was last written.
module ysyx_23060236_icache #(
   parameter int INDEX_BITS = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [24:0] icache_araddr,
   output logic [31:0] icache_rdata,
   output logic        icache_hit,
   input  logic [24:0] icache_awaddr,
   input  logic [31:0] icache_wdata,
   input  logic        icache_wvalid,
   input  logic        fence_i
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 20 - INDEX_BITS;

   logic [LINES-1:0]      valid;
   logic [TAG_W-1:0]      tag_mem  [LINES];
   logic [31:0]           data_mem [LINES][8];

   logic [INDEX_BITS-1:0] r_idx;
   logic [TAG_W-1:0]      r_tag;
   logic [2:0]            r_word;
   logic [INDEX_BITS-1:0] w_idx;
   logic [TAG_W-1:0]      w_tag;
   logic [2:0]            w_word;
   logic                  unused_low_bits;

   assign r_idx  = icache_araddr[4+INDEX_BITS:5];
   assign r_tag  = icache_araddr[24:5+INDEX_BITS];
   assign r_word = icache_araddr[4:2];
   assign w_idx  = icache_awaddr[4+INDEX_BITS:5];
   assign w_tag  = icache_awaddr[24:5+INDEX_BITS];
   assign w_word = icache_awaddr[4:2];

   // Byte offsets within a word are irrelevant to a word-wide cache.
   assign unused_low_bits = &{1'b0, icache_araddr[1:0], icache_awaddr[1:0]};

   always_comb begin
      icache_hit   = valid[r_idx] && (tag_mem[r_idx] == r_tag);
      icache_rdata = data_mem[r_idx][r_word];
   end

   // Priority: reset, then fence_i, then the fill-start clear / fill-complete set.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid <= '0;
      end else if (fence_i) begin
         valid <= '0;
      end else if (icache_wvalid && (w_word == 3'd0)) begin
         valid[w_idx] <= 1'b0;
      end else if (icache_wvalid && (w_word == 3'd7)) begin
         valid[w_idx] <= 1'b1;
      end
   end

   // Word 7 carries the tag so the line becomes consistent exactly when it turns valid.
   always_ff @(posedge clock) begin
      if (!reset && icache_wvalid) begin
         data_mem[w_idx][w_word] <= icache_wdata;
         if (w_word == 3'd7) begin
            tag_mem[w_idx] <= w_tag;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060236_icache.sv
// Directed bench for the icache: expected read results are queued as reads are issued
// and popped when the combinational output is sampled.
module tb_ysyx_23060236_icache;

   logic        clock;
   logic        reset;
   logic [24:0] icache_araddr;
   logic [31:0] icache_rdata;
   logic        icache_hit;
   logic [24:0] icache_awaddr;
   logic [31:0] icache_wdata;
   logic        icache_wvalid;
   logic        fence_i;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic        hit;
      logic [31:0] data;
      bit          chk_data;
   } exp_t;

   exp_t sb[$];

   ysyx_23060236_icache #(.INDEX_BITS(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .icache_araddr(icache_araddr),
      .icache_rdata (icache_rdata),
      .icache_hit   (icache_hit),
      .icache_awaddr(icache_awaddr),
      .icache_wdata (icache_wdata),
      .icache_wvalid(icache_wvalid),
      .fence_i      (fence_i)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic expect_read(input string name, input logic hit, input logic [31:0] data,
                              input bit chk_data);
      exp_t e;
      e.name     = name;
      e.hit      = hit;
      e.data     = data;
      e.chk_data = chk_data;
      sb.push_back(e);
   endtask

   // Compare the oldest queued expectation against the current outputs.
   task automatic compare_head();
      exp_t e;
      e = sb.pop_front();
      checks++;
      assert (icache_hit === e.hit) else begin
         errors++;
         $error("FAIL %s hit: got %0b expected %0b", e.name, icache_hit, e.hit);
      end
      if (e.chk_data) begin
         checks++;
         assert (icache_rdata === e.data) else begin
            errors++;
            $error("FAIL %s rdata: got %08h expected %08h", e.name, icache_rdata, e.data);
         end
      end
   endtask

   // Called just after a falling edge, so the read settles well away from the rising edge.
   task automatic read_chk(input string name, input logic [24:0] addr, input logic hit,
                           input logic [31:0] data, input bit chk_data);
      icache_araddr = addr;
      expect_read(name, hit, data, chk_data);
      #1;
      compare_head();
   endtask

   task automatic write_beat(input logic [24:0] addr, input logic [31:0] data);
      icache_awaddr = addr;
      icache_wdata  = data;
      icache_wvalid = 1'b1;
      @(negedge clock);
      icache_wvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   initial begin
      reset         = 1'b1;
      fence_i       = 1'b0;
      icache_araddr = '0;
      icache_awaddr = '0;
      icache_wdata  = '0;
      icache_wvalid = 1'b0;
      idle(3);
      reset = 1'b0;

      read_chk("reset_addr0", 25'h0000000, 1'b0, '0, 1'b0);
      read_chk("reset_other", 25'h1ABCDE4, 1'b0, '0, 1'b0);

      // Line 1, tag 0, with gaps between some beats.
      for (int k = 0; k < 4; k++) begin
         write_beat(25'h0000020 + 25'(4 * k), 32'h1000 + 32'(k));
         if (k == 1) idle(2);
      end
      read_chk("mid_fill_miss", 25'h0000020, 1'b0, '0, 1'b0);
      for (int k = 4; k < 8; k++) write_beat(25'h0000020 + 25'(4 * k), 32'h1000 + 32'(k));
      read_chk("fill_hit_w3", 25'h000002C, 1'b1, 32'h1003, 1'b1);
      read_chk("fill_other_tag", 25'h100002C, 1'b0, '0, 1'b0);
      read_chk("fill_hit_w0", 25'h0000020, 1'b1, 32'h1000, 1'b1);
      read_chk("byte_bits_ignored", 25'h0000023, 1'b1, 32'h1000, 1'b1);
      read_chk("fill_hit_w7", 25'h000003C, 1'b1, 32'h1007, 1'b1);

      // Line 2, then overwrite a middle word while reading it in the same cycle.
      for (int k = 0; k < 8; k++) write_beat(25'h0000040 + 25'(4 * k), 32'h2000 + 32'(k));
      icache_awaddr = 25'h000004C;
      icache_wdata  = 32'hDEAD;
      icache_wvalid = 1'b1;
      read_chk("no_bypass_old", 25'h000004C, 1'b1, 32'h2003, 1'b1);
      @(negedge clock);
      icache_wvalid = 1'b0;
      read_chk("mid_word_new", 25'h000004C, 1'b1, 32'hDEAD, 1'b1);
      read_chk("other_line_kept", 25'h000002C, 1'b1, 32'h1003, 1'b1);

      // Refill line 1 with tag B (bit 9 set).
      write_beat(25'h0000220, 32'h3000);
      read_chk("refill_old_tag_miss", 25'h000002C, 1'b0, '0, 1'b0);
      for (int k = 1; k < 8; k++) write_beat(25'h0000220 + 25'(4 * k), 32'h3000 + 32'(k));
      read_chk("refill_new_tag_hit", 25'h000022C, 1'b1, 32'h3003, 1'b1);
      read_chk("refill_old_tag_gone", 25'h000002C, 1'b0, '0, 1'b0);

      // fence_i invalidates everything.
      fence_i = 1'b1;
      @(negedge clock);
      fence_i = 1'b0;
      read_chk("fence_line1_miss", 25'h000022C, 1'b0, '0, 1'b0);
      read_chk("fence_line2_miss", 25'h000004C, 1'b0, '0, 1'b0);

      // fence_i coinciding with the word-7 beat keeps the line invalid.
      for (int k = 0; k < 7; k++) write_beat(25'h0000060 + 25'(4 * k), 32'h4000 + 32'(k));
      fence_i = 1'b1;
      write_beat(25'h000007C, 32'h4007);
      fence_i = 1'b0;
      read_chk("fence_w7_miss", 25'h000007C, 1'b0, '0, 1'b0);
      write_beat(25'h000007C, 32'h4077);
      read_chk("w7_after_fence_hit", 25'h000007C, 1'b1, 32'h4077, 1'b1);
      read_chk("w0_data_kept", 25'h0000060, 1'b1, 32'h4000, 1'b1);

      // Reset arrives on beat 5 of a line-4 fill; only beats 6 and 7 follow.
      for (int k = 0; k < 5; k++) write_beat(25'h0000080 + 25'(4 * k), 32'h5000 + 32'(k));
      reset = 1'b1;
      write_beat(25'h0000094, 32'h5005);
      reset = 1'b0;
      read_chk("reset_midfill_miss", 25'h0000080, 1'b0, '0, 1'b0);
      read_chk("reset_clears_line3", 25'h000007C, 1'b0, '0, 1'b0);
      write_beat(25'h0000098, 32'h5006);
      read_chk("after_w6_miss", 25'h0000098, 1'b0, '0, 1'b0);
      write_beat(25'h000009C, 32'h5007);
      read_chk("after_w7_hit_w6", 25'h0000098, 1'b1, 32'h5006, 1'b1);
      read_chk("after_w7_hit_w7", 25'h000009C, 1'b1, 32'h5007, 1'b1);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
